mul_seq_ctrl: RTL and testbench

Sequencing FSM for the shift-add multiplier datapath: operand registers A (multiplicand, shifts left) and B (multiplier, shifts right), plus the 2*WIDTH-bit product register P with load/clear.
- Accepts a start request and issues the per-cycle load, clear and shift strobes.
- Counts iterations and signals completion with a one-cycle done pulse.
- Sits between the top-level operand interface and the register/adder datapath.
- Contains no datapath storage of its own.

---
 rtl/mul_pkg.sv | 20 ++
 rtl/mul_iter_cnt.sv | 36 +++
 rtl/mul_seq_ctrl.sv | 113 +++++++++++
 tb/tb_mul_seq_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and sizing helpers for the shift-add multiplier sequencer.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        CALC = 2'b10,
        DONE = 2'b11
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bits needed to hold an iteration count from 0 up to and including width.
    function automatic int iterWidth(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int ITER_W = iterWidth(DEFAULT_WIDTH);

endpackage

// File: rtl/mul_iter_cnt.sv
// Iteration counter for the multiplier sequencer: saturates at WIDTH and flags
// the last iteration (count == WIDTH-1).
module mul_iter_cnt
    import mul_pkg::*;
#(
    parameter  int WIDTH  = DEFAULT_WIDTH,
    localparam int CNT_W  = iterWidth(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [CNT_W-1:0] o_count,
    output logic             o_tc
);

    localparam logic [CNT_W-1:0] LIMIT  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] r_count;

    // Holding at LIMIT keeps the count from wrapping even if enable is misused.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LIMIT)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == TC_VAL);

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequencing FSM for the shift-add multiplier: issues load/clear/shift strobes,
// counts iterations and pulses done once per completed multiply.
module mul_seq_ctrl
    import mul_pkg::*;
#(
    parameter  int WIDTH      = DEFAULT_WIDTH,
    parameter  bit EARLY_EXIT = 1'b0,
    localparam int CNT_W      = iterWidth(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             b_lsb,
    input  logic             b_zero,
    output logic             ld_A,
    output logic             ld_B,
    output logic             clr_P,
    output logic             ld_P,
    output logic             shift,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] iter
);

    state_t r_state;
    logic   r_load;
    logic   r_calc;
    logic   r_busy;
    logic   r_done;

    logic   w_early;
    logic   w_step;
    logic   w_clear;
    logic   w_tc;

    // Early exit only counts inside CALC, so a floating b_zero elsewhere is harmless.
    assign w_early = EARLY_EXIT && r_calc && b_zero;
    assign w_step  = r_calc && !abort && !w_early;
    assign w_clear = r_load && !abort;

    mul_iter_cnt #(
        .WIDTH    (WIDTH)
    ) u_iter_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_clear),
        .i_enable (w_step),
        .o_count  (iter),
        .o_tc     (w_tc)
    );

    // State flags are registered alongside the state so outputs decode from flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_load  <= 1'b0;
            r_calc  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_load <= 1'b0;
            r_calc <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= LOAD;
                        r_load  <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        r_state <= IDLE;
                    end else begin
                        r_state <= CALC;
                        r_calc  <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                CALC: begin
                    if (abort) begin
                        r_state <= IDLE;
                    end else if (w_early || w_tc) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_calc  <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // An abort silences every strobe in the cycle it is seen.
    assign ld_A  = r_load && !abort;
    assign ld_B  = r_load && !abort;
    assign clr_P = r_load && !abort;
    assign shift = w_step;
    assign ld_P  = w_step && b_lsb;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: one instance per EARLY_EXIT setting,
// each driving a small shift-add datapath model, checked against a cycle model.
module tb_mul_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] start;
    logic [1:0] abort;
    logic [1:0] bLsb;
    logic [1:0] bZero;
    logic [1:0] ldA;
    logic [1:0] ldB;
    logic [1:0] clrP;
    logic [1:0] ldP;
    logic [1:0] shift;
    logic [1:0] busy;
    logic [1:0] done;
    logic [3:0] iter0;
    logic [3:0] iter1;

    logic [7:0]  aOp [2];
    logic [7:0]  bOp [2];
    logic [15:0] regA [2];
    logic [15:0] regP [2];
    logic [7:0]  regB [2];

    int nComp = 0;
    int nFail = 0;
    int lastIter [2];

    always #5 clk = ~clk;

    mul_seq_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
        .b_lsb(bLsb[0]), .b_zero(bZero[0]), .ld_A(ldA[0]), .ld_B(ldB[0]),
        .clr_P(clrP[0]), .ld_P(ldP[0]), .shift(shift[0]), .busy(busy[0]),
        .done(done[0]), .iter(iter0)
    );

    mul_seq_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
        .b_lsb(bLsb[1]), .b_zero(bZero[1]), .ld_A(ldA[1]), .ld_B(ldB[1]),
        .clr_P(clrP[1]), .ld_P(ldP[1]), .shift(shift[1]), .busy(busy[1]),
        .done(done[1]), .iter(iter1)
    );

    // Register/adder datapath driven by each controller's strobes.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ldA[i]) regA[i] <= {8'h00, aOp[i]};
            else if (shift[i]) regA[i] <= regA[i] << 1;
            if (ldB[i]) regB[i] <= bOp[i];
            else if (shift[i]) regB[i] <= regB[i] >> 1;
            if (clrP[i]) regP[i] <= 16'h0000;
            else if (ldP[i]) regP[i] <= regP[i] + regA[i];
        end
    end

    assign bLsb[0]  = regB[0][0];
    assign bLsb[1]  = regB[1][0];
    assign bZero[0] = (regB[0] == 8'h00);
    assign bZero[1] = (regB[1] == 8'h00);

    function automatic logic [6:0] outs(input int d);
        return {ldA[d], ldB[d], clrP[d], ldP[d], shift[d], busy[d], done[d]};
    endfunction

    // Number of significant bits in the multiplier (0 for zero).
    function automatic int bitLen(input logic [7:0] v);
        int n = 0;
        while (n < 8 && (v >> n) != 8'h00) n++;
        return n;
    endfunction

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic compareVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nComp++;
        assert (obs === expv) else begin
            nFail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Strobe vector order: ld_A ld_B clr_P ld_P shift busy done.
    task automatic checkOutput(input string tag, input int d, input logic [6:0] expV, input int expI);
        logic [3:0] it;
        #1;
        it = (d == 1) ? iter1 : iter0;
        compareVal({tag, " strobes"}, 32'(outs(d)), 32'(expV));
        compareVal({tag, " iter"}, 32'(it), 32'(expI));
    endtask

    // One multiply on DUT d; abortAt/rstAt give the cycle (1 = LOAD) to abort or reset in.
    task automatic applyStimulus(input int d, input logic [7:0] a, input logic [7:0] b,
                                 input int abortAt, input int rstAt);
        int k;
        int extra;
        int calc;
        int expI;
        logic [6:0] expV;
        logic [15:0] prod;
        k     = (d == 1) ? bitLen(b) : 8;
        extra = (d == 1 && k < 8) ? 1 : 0;
        calc  = k + extra;
        prod  = 16'(a) * 16'(b);
        aOp[d] = a;
        bOp[d] = b;
        start[d] = 1'b1;
        abort[d] = 1'($urandom_range(0, 1));
        nextCycle();
        start[d] = 1'b0;
        for (int c = 1; c <= 3 + calc; c++) begin
            if (c == 1) expI = lastIter[d];
            else if (c <= 1 + k) expI = c - 2;
            else expI = k;
            if (c == 1) expV = 7'b1110010;
            else if (c <= 1 + k) expV = {3'b000, b[c-2], 3'b110};
            else if (c <= 1 + calc) expV = 7'b0000010;
            else if (c == 2 + calc) expV = 7'b0000001;
            else expV = 7'b0000000;
            if (c == abortAt && c <= 1 + calc) begin
                abort[d] = 1'b1;
                expV = 7'b0000010;
            end else if (c >= 2 + calc) begin
                abort[d] = 1'($urandom_range(0, 1));
            end else begin
                abort[d] = 1'b0;
            end
            rst_n = (c == rstAt) ? 1'b0 : 1'b1;
            checkOutput($sformatf("op%0d a%02h b%02h c%0d", d, a, b, c), d, expV, expI);
            if (c == 2 + calc) compareVal($sformatf("product %02h*%02h", a, b), 32'(regP[d]), 32'(prod));
            if (abort[d] && c <= 1 + calc) begin
                nextCycle();
                abort[d] = 1'b0;
                checkOutput("post-abort", d, 7'b0000000, expI);
                lastIter[d] = expI;
                return;
            end
            if (!rst_n) begin
                nextCycle();
                rst_n = 1'b1;
                checkOutput("post-reset", d, 7'b0000000, 0);
                lastIter[0] = 0;
                lastIter[1] = 0;
                return;
            end
            nextCycle();
        end
        abort[d] = 1'b0;
        lastIter[d] = k;
    endtask

    initial begin
        int d;
        int ab;
        logic [7:0] a;
        logic [7:0] b;
        lastIter[0] = 0;
        lastIter[1] = 0;

        // Reset dominates start and abort.
        rst_n = 1'b0;
        start = 2'b11;
        abort = 2'b11;
        nextCycle();
        nextCycle();
        checkOutput("reset d0", 0, 7'b0000000, 0);
        checkOutput("reset d1", 1, 7'b0000000, 0);
        start = 2'b00;
        abort = 2'b00;
        rst_n = 1'b1;
        nextCycle();
        checkOutput("idle d0", 0, 7'b0000000, 0);

        $display("[TB] directed runs");
        applyStimulus(0, 8'h0C, 8'hA5, -1, -1);
        compareVal("basic product const", 32'(regP[0]), 32'h0000_07BC);
        applyStimulus(0, 8'h37, 8'hFF, 5, -1);
        applyStimulus(0, 8'h21, 8'h9C, -1, 4);
        applyStimulus(0, 8'h44, 8'h81, -1, -1);
        applyStimulus(1, 8'h55, 8'h03, -1, -1);
        applyStimulus(1, 8'h12, 8'h00, -1, -1);
        applyStimulus(1, 8'hE7, 8'h80, -1, -1);
        applyStimulus(1, 8'h9B, 8'h40, -1, -1);
        applyStimulus(1, 8'h6D, 8'h1F, 1, -1);
        applyStimulus(0, 8'hC3, 8'h00, -1, -1);

        // Start held high: one LOAD and one done every 11 cycles.
        aOp[0] = 8'h5A;
        bOp[0] = 8'h3C;
        start[0] = 1'b1;
        abort[0] = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            nextCycle();
            #1;
            compareVal($sformatf("held ld_A c%0d", c), 32'(ldA[0]), 32'(((c - 1) % 11) == 0));
            compareVal($sformatf("held done c%0d", c), 32'(done[0]), 32'(((c - 1) % 11) == 9));
        end
        start[0] = 1'b0;
        nextCycle();
        checkOutput("held idle", 0, 7'b0000000, 8);
        lastIter[0] = 8;

        $display("[TB] random runs");
        repeat (24) begin
            d  = int'($urandom_range(0, 1));
            a  = 8'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 9)) : -1;
            applyStimulus(d, a, b, ab, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nComp, nFail);
        $finish;
    end

endmodule
